// File: rtl/twdl_idx_gen.sv
// twdl_idx_gen: twiddle index generator feeding the CTA twiddle multiplier.
// For one mixed-radix stage it walks every butterfly (k within block, then block) and issues
// per-lane numerators n*k, the common denominator L and the radix factor.
// Numerators come from per-lane accumulators, so no multipliers are used.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle stage request (sampled only in IDLE)
//   cfg_factor    radix (2..5)
//   cfg_demontr   twiddle denominator L = span*factor
//   cfg_span      butterflies per block (>= 1)
//   cfg_nblk      number of blocks (>= 1)
//   out_rdy       downstream ready
//   out_val       index set valid
//   twdl_numrtr   lane numerators n*k (0 for lanes >= factor)
//   twdl_demontr  latched L
//   factor        latched radix
//   blk_first     set is k==0 of its block
//   stg_last      set is the final butterfly of the stage
//   busy          high in LOAD and RUN
//   done          one-cycle pulse after the last transfer
//   cfg_err       one-cycle pulse on a rejected start
module twdl_idx_gen #(
    parameter int unsigned wIdx  = 12,
    parameter int unsigned nLane = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [2:0]                       cfg_factor,
    input  logic [wIdx-1:0]                  cfg_demontr,
    input  logic [wIdx-1:0]                  cfg_span,
    input  logic [wIdx-1:0]                  cfg_nblk,
    input  logic                             out_rdy,
    output logic                             out_val,
    output logic [0:nLane-1][wIdx-1:0]       twdl_numrtr,
    output logic [wIdx-1:0]                  twdl_demontr,
    output logic [2:0]                       factor,
    output logic                             blk_first,
    output logic                             stg_last,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    localparam logic [wIdx-1:0] One = wIdx'(1);

    state_e state_q, state_d;

    logic [2:0]                  factor_q, factor_d;
    logic [wIdx-1:0]             demontr_q, demontr_d;
    logic [wIdx-1:0]             span_q, span_d;
    logic [wIdx-1:0]             nblk_q, nblk_d;
    logic [wIdx-1:0]             k_q, k_d;
    logic [wIdx-1:0]             blk_q, blk_d;
    logic [0:nLane-1][wIdx-1:0]  acc_q, acc_d;
    logic                        out_val_q, out_val_d;
    logic                        blk_first_q, blk_first_d;
    logic                        stg_last_q, stg_last_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        cfg_err_q, cfg_err_d;

    logic            cfg_ok;
    logic            xfer;
    logic [wIdx-1:0] span_m1;
    logic [wIdx-1:0] nblk_m1;
    logic [wIdx-1:0] k_inc;
    logic [wIdx-1:0] blk_inc;

    assign cfg_ok  = (cfg_factor >= 3'd2) && (cfg_factor <= 3'd5) &&
                     (cfg_span != '0) && (cfg_nblk != '0);
    assign xfer    = out_val_q & out_rdy;
    assign span_m1 = span_q - One;
    assign nblk_m1 = nblk_q - One;
    assign k_inc   = k_q + One;
    assign blk_inc = blk_q + One;

    always_comb begin
        state_d     = state_q;
        factor_d    = factor_q;
        demontr_d   = demontr_q;
        span_d      = span_q;
        nblk_d      = nblk_q;
        k_d         = k_q;
        blk_d       = blk_q;
        acc_d       = acc_q;
        out_val_d   = out_val_q;
        blk_first_d = blk_first_q;
        stg_last_d  = stg_last_q;
        cfg_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_ok) begin
                        factor_d  = cfg_factor;
                        demontr_d = cfg_demontr;
                        span_d    = cfg_span;
                        nblk_d    = cfg_nblk;
                        state_d   = StLoad;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                k_d         = '0;
                blk_d       = '0;
                acc_d       = '0;
                out_val_d   = 1'b1;
                blk_first_d = 1'b1;
                stg_last_d  = (span_q == One) && (nblk_q == One);
                state_d     = StRun;
            end
            StRun: begin
                if (xfer) begin
                    if (k_q != span_m1) begin
                        k_d = k_inc;
                        // Lanes at or above factor are never stepped, so they stay 0.
                        for (int unsigned n = 0; n < nLane; n++) begin
                            if (3'(n) < factor_q) begin
                                acc_d[n] = acc_q[n] + wIdx'(n);
                            end
                        end
                        blk_first_d = 1'b0;
                        stg_last_d  = (k_inc == span_m1) && (blk_q == nblk_m1);
                    end else if (blk_q != nblk_m1) begin
                        k_d         = '0;
                        blk_d       = blk_inc;
                        acc_d       = '0;
                        blk_first_d = 1'b1;
                        stg_last_d  = (span_q == One) && (blk_inc == nblk_m1);
                    end else begin
                        out_val_d   = 1'b0;
                        blk_first_d = 1'b0;
                        stg_last_d  = 1'b0;
                        state_d     = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StLoad) || (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            factor_q    <= '0;
            demontr_q   <= '0;
            span_q      <= '0;
            nblk_q      <= '0;
            k_q         <= '0;
            blk_q       <= '0;
            acc_q       <= '0;
            out_val_q   <= 1'b0;
            blk_first_q <= 1'b0;
            stg_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            factor_q    <= factor_d;
            demontr_q   <= demontr_d;
            span_q      <= span_d;
            nblk_q      <= nblk_d;
            k_q         <= k_d;
            blk_q       <= blk_d;
            acc_q       <= acc_d;
            out_val_q   <= out_val_d;
            blk_first_q <= blk_first_d;
            stg_last_q  <= stg_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign out_val      = out_val_q;
    assign twdl_numrtr  = acc_q;
    assign twdl_demontr = demontr_q;
    assign factor       = factor_q;
    assign blk_first    = blk_first_q;
    assign stg_last     = stg_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_twdl_idx_gen.sv
// Bench for twdl_idx_gen: directed and randomized stages checked against a list of expected
// index sets built from the stage definition (n*k per lane, block/stage markers).
module tb_twdl_idx_gen;

    localparam int unsigned W = 12;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [2:0]              cfg_factor;
    logic [W-1:0]            cfg_demontr;
    logic [W-1:0]            cfg_span;
    logic [W-1:0]            cfg_nblk;
    logic                    out_rdy;
    logic                    out_val;
    logic [0:4][W-1:0]       twdl_numrtr;
    logic [W-1:0]            twdl_demontr;
    logic [2:0]              factor;
    logic                    blk_first;
    logic                    stg_last;
    logic                    busy;
    logic                    done;
    logic                    cfg_err;

    twdl_idx_gen #(.wIdx(W), .nLane(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_factor   (cfg_factor),
        .cfg_demontr  (cfg_demontr),
        .cfg_span     (cfg_span),
        .cfg_nblk     (cfg_nblk),
        .out_rdy      (out_rdy),
        .out_val      (out_val),
        .twdl_numrtr  (twdl_numrtr),
        .twdl_demontr (twdl_demontr),
        .factor       (factor),
        .blk_first    (blk_first),
        .stg_last     (stg_last),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0][31:0] num;
        logic             bf;
        logic             sl;
    } set_t;

    set_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected sequence: blocks outer, butterflies inner; lane n carries n*k below factor.
    task automatic build(input int f, input int sp, input int nb);
        set_t s;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < sp; k++) begin
                for (int n = 0; n < 5; n++) s.num[n] = (n < f) ? 32'(n * k) : 32'd0;
                s.bf = (k == 0);
                s.sl = (b == nb - 1) && (k == sp - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_val"}, 32'(out_val), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_bf"}, 32'(blk_first), 32'd0);
        chk({tag, "_sl"}, 32'(stg_last), 32'd0);
        chk({tag, "_den"}, 32'(twdl_demontr), 32'd0);
        chk({tag, "_fac"}, 32'(factor), 32'd0);
        for (int n = 0; n < 5; n++) chk({tag, "_num"}, 32'(twdl_numrtr[n]), 32'd0);
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    // restart_at: loop cycle at which a stray start with other cfg is pulsed (-1 none).
    // abort_at: set index at which the bench stalls, then resets the DUT (-1 none).
    task automatic run_stage(input int f, input int sp, input int nb, input int rmode,
                             input int restart_at, input int abort_at);
        int idx   = 0;
        int cyc   = 0;
        int stall = 0;
        int total;
        bit fin   = 0;
        bit rst_now;
        build(f, sp, nb);
        total = exp_q.size();
        @(posedge clk); #1;
        cfg_factor  = 3'(f);
        cfg_demontr = W'(f * sp);
        cfg_span    = W'(sp);
        cfg_nblk    = W'(nb);
        start       = 1'b1;
        out_rdy     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_val", 32'(out_val), 32'd0);
        while (!fin && cyc < 400) begin
            @(posedge clk); #1;
            rst_now = 1'b0;
            start = (cyc == restart_at);
            if (start) begin
                cfg_factor  = 3'd5;
                cfg_span    = W'(7);
                cfg_nblk    = W'(2);
                cfg_demontr = W'(35);
            end
            case (rmode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_rdy = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && idx == abort_at) begin
                out_rdy = 1'b0;
                stall++;
                if (stall == 3) begin
                    rst     = 1'b1;
                    rst_now = 1'b1;
                end
            end
            @(negedge clk);
            chk("run_done", 32'(done), 32'd0);
            chk("run_val", 32'(out_val), 32'd1);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_den", 32'(twdl_demontr), 32'(f * sp));
            chk("run_fac", 32'(factor), 32'(f));
            for (int n = 0; n < 5; n++) chk("run_num", 32'(twdl_numrtr[n]), exp_q[idx].num[n]);
            chk("run_bf", 32'(blk_first), 32'(exp_q[idx].bf));
            chk("run_sl", 32'(stg_last), 32'(exp_q[idx].sl));
            if (rst_now) begin
                @(posedge clk); #1;
                rst     = 1'b0;
                out_rdy = 1'b0;
                @(negedge clk);
                chk_idle_zero("rst_mid");
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("rst_nodone", 32'(done), 32'd0);
                    chk("rst_noval", 32'(out_val), 32'd0);
                end
                return;
            end
            if (out_rdy) begin
                idx++;
                if (idx == total) begin
                    @(posedge clk); #1;
                    out_rdy = 1'b0;
                    @(negedge clk);
                    chk("end_done", 32'(done), 32'd1);
                    chk("end_val", 32'(out_val), 32'd0);
                    chk("end_busy", 32'(busy), 32'd0);
                    @(negedge clk);
                    chk("end_done_pulse", 32'(done), 32'd0);
                    fin = 1;
                end
            end
            cyc++;
        end
        if (!fin) chk("timeout_xfers", 32'(idx), 32'(total));
    endtask

    task automatic bad_start(input int f, input int sp, input int nb);
        @(posedge clk); #1;
        cfg_factor  = 3'(f);
        cfg_demontr = W'(f * sp);
        cfg_span    = W'(sp);
        cfg_nblk    = W'(nb);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("bad_err", 32'(cfg_err), 32'd1);
        chk("bad_val", 32'(out_val), 32'd0);
        chk("bad_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("bad_err_pulse", 32'(cfg_err), 32'd0);
        chk("bad_val2", 32'(out_val), 32'd0);
        chk("bad_busy2", 32'(busy), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        out_rdy     = 1'b0;
        cfg_factor  = '0;
        cfg_demontr = '0;
        cfg_span    = '0;
        cfg_nblk    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_stage(4, 4, 2, 0, -1, -1);
        run_stage(5, 5, 1, 1, -1, -1);
        run_stage(3, 1, 3, 0, -1, -1);
        bad_start(6, 4, 2);
        bad_start(4, 0, 2);
        bad_start(4, 4, 0);
        bad_start(1, 2, 2);
        bad_start(7, 3, 1);
        run_stage(4, 4, 2, 0, -1, 3);
        run_stage(4, 4, 2, 0, -1, -1);
        run_stage(4, 4, 2, 0, 2, -1);
        run_stage(2, 4, 2, 1, 0, -1);
        for (int i = 0; i < 8; i++) begin
            run_stage(int'($urandom_range(2, 5)), int'($urandom_range(1, 6)),
                      int'($urandom_range(1, 3)), 2, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
